// File: rtl/cluster_periph_arb_pkg.sv
// Shared types and defaults for the cluster peripheral arbiter.
// Master-index width follows the default master count; outstanding depth defaults to 2.
package cluster_periph_arb_pkg;

    localparam int NB_MASTERS_DFLT      = 4;
    localparam int MAX_OUTSTANDING_DFLT = 2;
    localparam int MST_IDX_W            = $clog2(NB_MASTERS_DFLT);

    typedef logic [MST_IDX_W-1:0] mst_idx_t;

endpackage

// File: rtl/periph_arb_idx_fifo.sv
// In-order queue of granted master indices; head is valid combinationally, 1-cycle push-to-head.
// Pushes are dropped when full and pops when empty; simultaneous push/pop keeps occupancy.
module periph_arb_idx_fifo
    import cluster_periph_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DFLT,
    parameter int WIDTH = MST_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] idx,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= idx;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (!push_ok && pop_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cluster_periph_arbiter.sv
// Round-robin N:1 arbiter onto the cluster control slave; requests forwarded with 0 latency, responses routed in order.
// Stalls (s_req_o low) while MAX_OUTSTANDING responses are pending. CLUSTER_PERIPH_ARB_HIPRIO_EN gives master 0 fixed priority.
module cluster_periph_arbiter
    import cluster_periph_arb_pkg::*;
#(
    parameter int NB_MASTERS      = NB_MASTERS_DFLT,
    parameter int ID_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DFLT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NB_MASTERS-1:0]        m_req_i,
    input  logic [NB_MASTERS*32-1:0]     m_add_i,
    input  logic [NB_MASTERS-1:0]        m_wen_i,
    input  logic [NB_MASTERS*32-1:0]     m_wdata_i,
    input  logic [NB_MASTERS*4-1:0]      m_be_i,
    input  logic [NB_MASTERS*ID_WIDTH-1:0] m_id_i,
    output logic [NB_MASTERS-1:0]        m_gnt_o,
    output logic [NB_MASTERS-1:0]        m_r_valid_o,
    output logic [31:0]                  m_r_rdata_o,
    output logic [ID_WIDTH-1:0]          m_r_id_o,
    output logic                         m_r_opc_o,
    output logic                         s_req_o,
    output logic [31:0]                  s_add_o,
    output logic                         s_wen_o,
    output logic [31:0]                  s_wdata_o,
    output logic [3:0]                   s_be_o,
    output logic [ID_WIDTH-1:0]          s_id_o,
    input  logic                         s_gnt_i,
    input  logic                         s_r_valid_i,
    input  logic [31:0]                  s_r_rdata_i,
    input  logic [ID_WIDTH-1:0]          s_r_id_i,
    input  logic                         s_r_opc_i,
    output logic                         err_o
);

    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic             hold_ptr;
    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             handshake;
    logic             pop;

    // Winner search depends only on m_req_i and rr_ptr, never on s_r_*.
    always_comb begin
        int j;
        logic found;
        j        = 0;
        found    = 1'b0;
        winner   = '0;
        hold_ptr = 1'b0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NB_MASTERS) begin
                j = j - NB_MASTERS;
            end
            if (!found && m_req_i[j]) begin
                found  = 1'b1;
                winner = j[IDX_W-1:0];
            end
        end
`ifdef CLUSTER_PERIPH_ARB_HIPRIO_EN
        // Master 0 preempts the rotation and leaves the pointer where it was.
        if (m_req_i[0]) begin
            winner   = '0;
            hold_ptr = 1'b1;
        end
`endif
    end

    assign rr_next   = (winner == IDX_W'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
    assign any_req   = |m_req_i;
    assign s_req_o   = rst_ni & any_req & ~fifo_full;
    assign handshake = s_req_o & s_gnt_i;

    assign s_add_o   = m_add_i[32*winner +: 32];
    assign s_wdata_o = m_wdata_i[32*winner +: 32];
    assign s_wen_o   = m_wen_i[winner];
    assign s_be_o    = m_be_i[4*winner +: 4];
    assign s_id_o    = m_id_i[ID_WIDTH*winner +: ID_WIDTH];

    always_comb begin
        m_gnt_o = '0;
        if (handshake) begin
            m_gnt_o[winner] = 1'b1;
        end
    end

    assign pop = s_r_valid_i & ~fifo_empty;

    always_comb begin
        m_r_valid_o = '0;
        if (pop) begin
            m_r_valid_o[head] = 1'b1;
        end
    end

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_id_o    = s_r_id_i;
    assign m_r_opc_o   = s_r_opc_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake && !hold_ptr) begin
            rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (s_r_valid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    periph_arb_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_idx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (handshake),
        .idx    (winner),
        .pop    (pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// Scoreboarded bench for cluster_periph_arbiter: a slave model answers after resp_delay cycles,
// expected responses are queued at each handshake and checked when m_r_valid_o fires.
module tb_cluster_periph_arbiter;

    localparam int NB  = 4;
    localparam int IDW = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [NB-1:0]    m_req_i = '0;
    logic [NB*32-1:0] m_add_i = '0;
    logic [NB-1:0]    m_wen_i = '0;
    logic [NB*32-1:0] m_wdata_i = '0;
    logic [NB*4-1:0]  m_be_i = '0;
    logic [NB*IDW-1:0] m_id_i = '0;
    logic [NB-1:0]    m_gnt_o;
    logic [NB-1:0]    m_r_valid_o;
    logic [31:0]      m_r_rdata_o;
    logic [IDW-1:0]   m_r_id_o;
    logic             m_r_opc_o;
    logic             s_req_o;
    logic [31:0]      s_add_o;
    logic             s_wen_o;
    logic [31:0]      s_wdata_o;
    logic [3:0]       s_be_o;
    logic [IDW-1:0]   s_id_o;
    logic             s_gnt_i = 1'b0;
    logic             s_r_valid_i;
    logic [31:0]      s_r_rdata_i;
    logic [IDW-1:0]   s_r_id_i;
    logic             s_r_opc_i;
    logic             err_o;

    typedef struct { int due; int mst; logic [IDW-1:0] id; } exp_t;
    typedef struct { int due; logic [IDW-1:0] id; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    gnt_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_delay = 1;

    logic [31:0]    add_a   [NB];
    logic [31:0]    wdata_a [NB];
    logic [3:0]     be_a    [NB];
    logic [IDW-1:0] id_a    [NB];
    logic           wen_a   [NB];

    always #5 clk_i = ~clk_i;

    cluster_periph_arbiter #(
        .NB_MASTERS      (NB),
        .ID_WIDTH        (IDW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m_req_i     (m_req_i),
        .m_add_i     (m_add_i),
        .m_wen_i     (m_wen_i),
        .m_wdata_i   (m_wdata_i),
        .m_be_i      (m_be_i),
        .m_id_i      (m_id_i),
        .m_gnt_o     (m_gnt_o),
        .m_r_valid_o (m_r_valid_o),
        .m_r_rdata_o (m_r_rdata_o),
        .m_r_id_o    (m_r_id_o),
        .m_r_opc_o   (m_r_opc_o),
        .s_req_o     (s_req_o),
        .s_add_o     (s_add_o),
        .s_wen_o     (s_wen_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_id_o      (s_id_o),
        .s_gnt_i     (s_gnt_i),
        .s_r_valid_i (s_r_valid_i),
        .s_r_rdata_i (s_r_rdata_i),
        .s_r_id_i    (s_r_id_i),
        .s_r_opc_i   (s_r_opc_i),
        .err_o       (err_o)
    );

    function automatic logic [31:0] rdata_of(input logic [IDW-1:0] id);
        return 32'hC0DE_0000 + 32'(id) * 32'd7;
    endfunction

    // Slave model plus response scoreboard; samples 4 time units after each negedge.
    initial begin
        exp_t e;
        logic [NB-1:0] exp_vld;
        int w;
        s_r_valid_i = 1'b0;
        s_r_rdata_i = '0;
        s_r_id_i    = '0;
        s_r_opc_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                s_r_valid_i = 1'b1;
                s_r_id_i    = pend_q[0].id;
                s_r_rdata_i = rdata_of(pend_q[0].id);
                s_r_opc_i   = pend_q[0].id[0];
                void'(pend_q.pop_front());
            end else begin
                s_r_valid_i = 1'b0;
                s_r_id_i    = '0;
                s_r_rdata_i = '0;
                s_r_opc_i   = 1'b0;
            end
            #4;
            if (!rst_ni) begin
                pend_q.delete();
                exp_q.delete();
            end else begin
                if ((exp_q.size() > 0 && exp_q[0].due == cyc) || m_r_valid_o != '0) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL resp_unexpected: m_r_valid_o=%b, required 0000", m_r_valid_o);
                    end else begin
                        e = exp_q.pop_front();
                        exp_vld = NB'(1 << e.mst);
                        if (m_r_valid_o !== exp_vld || m_r_id_o !== e.id || m_r_rdata_o !== rdata_of(e.id) ||
                            m_r_opc_o !== e.id[0] || cyc != e.due) begin
                            bad++;
                            $display("FAIL resp_match: got vld=%b id=%0d data=%h opc=%b cyc=%0d, required vld=%b id=%0d data=%h opc=%b cyc=%0d",
                                     m_r_valid_o, m_r_id_o, m_r_rdata_o, m_r_opc_o, cyc,
                                     exp_vld, e.id, rdata_of(e.id), e.id[0], e.due);
                        end
                    end
                end
                if (s_req_o && s_gnt_i) begin
                    w = -1;
                    for (int i = 0; i < NB; i++) begin
                        if (m_gnt_o == NB'(1 << i)) w = i;
                    end
                    total++;
                    if (w < 0) begin
                        bad++;
                        $display("FAIL gnt_onehot: m_gnt_o=%b, required one-hot", m_gnt_o);
                    end else begin
                        pend_q.push_back('{cyc + resp_delay, s_id_o});
                        exp_q.push_back('{cyc + resp_delay, w, id_a[w]});
                    end
                    gnt_log.push_back(w);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < NB; i++) begin
            add_a[i]   = 32'h1000_0000 + 32'(i) * 32'h44;
            wdata_a[i] = 32'hDEAD_0000 | 32'(i * 3 + 1);
            be_a[i]    = 4'hF >> i;
            id_a[i]    = IDW'(3 + i * 5);
            wen_a[i]   = (i % 2) == 1;
            m_add_i[i*32 +: 32]   = add_a[i];
            m_wdata_i[i*32 +: 32] = wdata_a[i];
            m_be_i[i*4 +: 4]      = be_a[i];
            m_id_i[i*IDW +: IDW]  = id_a[i];
            m_wen_i[i]            = wen_a[i];
        end
    endtask

    task automatic reset_dut();
        step();
        rst_ni  = 1'b0;
        m_req_i = '0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 30) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || pend_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: outstanding=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic check_log(input string name, input int exp_log[$]);
        total++;
        if (gnt_log.size() != exp_log.size()) begin
            bad++;
            $display("FAIL %s_count: grants=%0d, required %0d", name, gnt_log.size(), exp_log.size());
        end else begin
            for (int i = 0; i < exp_log.size(); i++) begin
                total++;
                if (gnt_log[i] !== exp_log[i]) begin
                    bad++;
                    $display("FAIL %s_order[%0d]: master=%0d, required %0d", name, i, gnt_log[i], exp_log[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive_fields();
        step();
        rst_ni  = 1'b0;
        m_req_i = '1;
        s_gnt_i = 1'b1;
        #3;
        total++;
        if (m_gnt_o !== '0 || m_r_valid_o !== '0 || s_req_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b rvld=%b sreq=%b, required 0000 0000 0", m_gnt_o, m_r_valid_o, s_req_o);
        end
        step();
        rst_ni  = 1'b1;
        m_req_i = '0;
        #3;
        total++;
        if (err_o !== 1'b0 || s_req_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: err=%b sreq=%b, required 0 0", err_o, s_req_o);
        end
    endtask

    task automatic test_round_robin();
        resp_delay = 1;
        gnt_log.delete();
        step();
        m_req_i = '1;
        repeat (5) step();
        m_req_i = '0;
        drain();
        check_log("rr", '{0, 1, 2, 3, 0});
    endtask

    task automatic test_backpressure();
        logic sreq_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        resp_delay = 3;
        gnt_log.delete();
        step();
        m_req_i = '1;
        for (int k = 0; k < 5; k++) begin
            #3;
            total++;
            if (s_req_o !== sreq_exp[k]) begin
                bad++;
                $display("FAIL bp_sreq[%0d]: s_req_o=%b, required %b", k, s_req_o, sreq_exp[k]);
            end
            step();
        end
        m_req_i = '0;
        drain();
        total++;
        if (gnt_log.size() != 3) begin
            bad++;
            $display("FAIL bp_grants: grants=%0d, required 3", gnt_log.size());
        end
    endtask

    task automatic test_rr_ptr2();
        reset_dut();
        resp_delay = 1;
        gnt_log.delete();
        step();
        m_req_i = 4'b0010;
        step();
        m_req_i = 4'b1010;
        step();
        step();
        m_req_i = '0;
        drain();
        check_log("ptr2", '{1, 3, 1});
    endtask

    task automatic test_fields();
        // rr_ptr is 2 here; a request without s_gnt_i must not move it.
        step();
        s_gnt_i = 1'b0;
        for (int k = 2; k < NB; k++) begin
            m_req_i = NB'(1 << k);
            #3;
            total++;
            if (s_req_o !== 1'b1 || m_gnt_o !== '0 || s_add_o !== add_a[k] || s_wdata_o !== wdata_a[k] ||
                s_be_o !== be_a[k] || s_id_o !== id_a[k] || s_wen_o !== wen_a[k]) begin
                bad++;
                $display("FAIL fields_m%0d: sreq=%b gnt=%b add=%h wd=%h be=%h id=%0d wen=%b, required 1 0000 %h %h %h %0d %b",
                         k, s_req_o, m_gnt_o, s_add_o, s_wdata_o, s_be_o, s_id_o, s_wen_o,
                         add_a[k], wdata_a[k], be_a[k], id_a[k], wen_a[k]);
            end
            step();
        end
        s_gnt_i = 1'b1;
        m_req_i = 4'b1100;
        #3;
        total++;
        if (m_gnt_o !== 4'b0100) begin
            bad++;
            $display("FAIL ptr_hold: m_gnt_o=%b, required 0100", m_gnt_o);
        end
        step();
        m_req_i = '0;
        drain();
    endtask

    task automatic test_err_inject();
        step();
        s_r_valid_i = 1'b1;
        s_r_id_i    = 5'd9;
        #3;
        total++;
        if (m_r_valid_o !== '0) begin
            bad++;
            $display("FAIL err_rvalid: m_r_valid_o=%b, required 0000", m_r_valid_o);
        end
        step();
        #3;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_set: err_o=%b, required 1", err_o);
        end
        repeat (3) step();
        #3;
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err_o=%b, required 1", err_o);
        end
        reset_dut();
        #3;
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err_o=%b, required 0", err_o);
        end
    endtask

    task automatic test_hiprio();
        reset_dut();
        resp_delay = 1;
        gnt_log.delete();
        step();
        m_req_i = 4'b0101;
        repeat (6) step();
        m_req_i = '0;
        drain();
`ifdef CLUSTER_PERIPH_ARB_HIPRIO_EN
        check_log("hiprio", '{0, 0, 0, 0, 0, 0});
`else
        check_log("hiprio", '{0, 2, 0, 2, 0, 2});
`endif
    endtask

    task automatic test_reset_mid();
        reset_dut();
        resp_delay = 3;
        step();
        m_req_i = '1;
        repeat (2) step();
        m_req_i = '0;
        rst_ni  = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #3;
            total++;
            if (m_r_valid_o !== '0) begin
                bad++;
                $display("FAIL midrst_rvalid[%0d]: m_r_valid_o=%b, required 0000", k, m_r_valid_o);
            end
            step();
        end
        m_req_i = '1;
        #3;
        total++;
        if (m_gnt_o !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_next_gnt: m_gnt_o=%b, required 0001", m_gnt_o);
        end
        step();
        m_req_i = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_rr_ptr2();
        test_fields();
        test_err_inject();
        test_hiprio();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cluster_periph_arbiter.md
CLUSTER_PERIPH_ARBITER -- requirements
Module: cluster_periph_arbiter

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 4, number of requesters sharing the cluster control slave port.
REQ-002 SHALL have parameter ID_WIDTH, default 5, width of the transaction id.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, number of accepted requests still awaiting a response.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 m_req_i  input  NB_MASTERS  per-master request.
REQ-007 m_add_i, m_wdata_i  input  NB_MASTERS x 32 each  per-master address and write data.
REQ-008 m_wen_i  input  NB_MASTERS  per-master read flag (1 = read, 0 = write).
REQ-009 m_be_i  input  NB_MASTERS x 4  per-master byte enables.
REQ-010 m_id_i  input  NB_MASTERS x ID_WIDTH  per-master transaction id.
REQ-011 m_gnt_o  output  NB_MASTERS  one-hot grant.
REQ-012 m_r_valid_o  output  NB_MASTERS  one-hot response valid.
REQ-013 m_r_rdata_o  output  32  response data, broadcast to all masters.
REQ-014 m_r_id_o  output  ID_WIDTH  response id, broadcast to all masters.
REQ-015 m_r_opc_o  output  1  response error flag, broadcast to all masters.
REQ-016 s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, s_id_o  output  1/32/1/32/4/ID_WIDTH  slave request channel.
REQ-017 s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_id_i, s_r_opc_i  input  1/1/32/ID_WIDTH/1  slave grant and response channel.
REQ-018 err_o  output  1  sticky flag: a response arrived with no request outstanding.

Function
REQ-019 A handshake SHALL occur when s_req_o and s_gnt_i are both 1 in the same cycle.
REQ-020 The winner SHALL be the first requesting master, searching upward from rr_ptr and wrapping modulo NB_MASTERS.
REQ-021 s_req_o SHALL be 1 only when at least one m_req_i bit is set and the outstanding FIFO is not full.
REQ-022 The s_* request fields SHALL equal the winner's fields, combinationally in the same cycle.
REQ-023 m_gnt_o[winner] SHALL equal s_gnt_i while s_req_o is 1; all other m_gnt_o bits SHALL be 0.
REQ-024 On each handshake, rr_ptr SHALL update to (winner+1) mod NB_MASTERS and the winner index SHALL be pushed into the FIFO.
REQ-025 With no handshake, rr_ptr SHALL hold.
REQ-026 Responses SHALL be in order: on s_r_valid_i, the FIFO head SHALL be popped and m_r_valid_o[head] SHALL be set in the same cycle.
REQ-027 m_r_rdata_o, m_r_id_o and m_r_opc_o SHALL pass through s_r_rdata_i, s_r_id_i and s_r_opc_i unchanged (0 cycles added).
REQ-028 FIFO full: no grant SHALL be issued, even if a pop occurs in the same cycle.
REQ-029 FIFO not full with push and pop in the same cycle: both SHALL occur and the occupancy SHALL be unchanged.
REQ-030 s_r_valid_i while the FIFO is empty: no m_r_valid_o bit SHALL be set and err_o SHALL be set to 1 until reset.
REQ-031 The block SHALL have zero-latency request forwarding and no combinational path from s_r_* to s_req_o.

Reset
REQ-032 On reset: rr_ptr = 0, FIFO empty, err_o = 0.
REQ-033 During reset: m_gnt_o = 0, m_r_valid_o = 0, s_req_o = 0.
REQ-034 Reset asserted mid-transaction SHALL discard all outstanding FIFO entries without generating any response.

Configuration
REQ-035 Macro CLUSTER_PERIPH_ARB_HIPRIO_EN defined: master 0 SHALL win whenever m_req_i[0] is 1, and rr_ptr SHALL not change on its grants.
REQ-036 With the macro defined, the remaining masters SHALL arbitrate round-robin as described in REQ-020 and REQ-024.
REQ-037 Macro undefined: all masters SHALL be pure round-robin.

Structure
REQ-038 Package cluster_periph_arb_pkg SHALL hold the master-index typedef (width $clog2(NB_MASTERS)) and the default MAX_OUTSTANDING constant.
REQ-039 The outstanding-index FIFO SHALL be sub-module periph_arb_idx_fifo, with push, pop, full, empty and head ports.

Verification
REQ-040 All 4 masters request continuously, s_gnt_i = 1, 1-cycle response -> grants in order 0,1,2,3,0; each m_r_valid_o arrives 1 cycle after its grant with the matching id.
REQ-041 MAX_OUTSTANDING = 2, s_gnt_i = 1, responses delayed 3 cycles -> exactly 2 grants, then s_req_o = 0 until the first response.
REQ-042 Masters 1 and 3 request, rr_ptr = 2 -> master 3 is granted first, then master 1.
REQ-043 s_r_valid_i pulsed with the FIFO empty -> m_r_valid_o = 0 and err_o = 1, which stays 1 until rst_ni is low.
REQ-044 CLUSTER_PERIPH_ARB_HIPRIO_EN defined, masters 0 and 2 request continuously -> master 0 is granted every cycle and master 2 is never granted.
REQ-045 rst_ni asserted with 2 requests outstanding, then released -> no m_r_valid_o pulse occurs and the next grant goes to master 0.
